multi_shift_register: RTL
=========================

MULTI_SHIFT_REGISTER -- requirements
Module: multi_shift_register

Interface
REQ-001 SHALL have parameter N, default 8: register width; legal values N >= 2.
REQ-002 SHALL have parameter CNT_W, default 4: width of the shift-count field.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: a command is presented.
REQ-006 SHALL have port cmd_ready, output, 1: a command can be accepted.
REQ-007 SHALL have port cmd_op, input, 3: operation code.
REQ-008 SHALL have port cmd_count, input, CNT_W: number of single-bit shifts.
REQ-009 SHALL have port parallel_in, input, N: load data.
REQ-010 SHALL have port ser_in, input, 1: serial fill bit, sampled on every RUN cycle.
REQ-011 SHALL have port abort, input, 1: synchronous abort of a running command.
REQ-012 SHALL have port parallel_out, output, N: register contents.
REQ-013 SHALL have port ser_out, output, 1: bit leaving the register in the current cycle.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-016 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL drive cmd_ready = (state == IDLE); a command is accepted on the edge where cmd_valid && cmd_ready.
REQ-018 SHALL decode cmd_op as: 000 LOAD, 001 SHL, 010 SHR, 011 ASR, 100 ROL, 101 ROR, 110 CLEAR, 111 NOP.
REQ-019 SHALL, on accepting LOAD, load parallel_in at the accept edge and go to DONE; cmd_count is ignored.
REQ-020 SHALL, on accepting CLEAR, load all zeros at the accept edge and go to DONE; cmd_count is ignored.
REQ-021 SHALL, on accepting NOP, leave the data unchanged and go to DONE.
REQ-022 SHALL, on accepting a shift or rotate op with cmd_count = 0, leave the data unchanged and go to DONE.
REQ-023 SHALL, on accepting a shift or rotate op with cmd_count = C > 0, latch the op, set remaining = C and go to RUN; the data is unchanged at the accept edge.
REQ-024 SHALL perform one single-bit operation per RUN edge and decrement remaining; it SHALL go to DONE on the edge that performs the shift with remaining == 1, so exactly C RUN cycles occur.
REQ-025 SHALL shift as follows: SHL gives {reg[N-2:0], ser_in}; SHR gives {ser_in, reg[N-1:1]}; ASR gives {reg[N-1], reg[N-1:1]}; ROL gives {reg[N-2:0], reg[N-1]}; ROR gives {reg[0], reg[N-1:1]}.
REQ-026 SHALL drive ser_out combinationally in RUN: reg[N-1] for SHL/ROL, reg[0] for SHR/ASR/ROR; ser_out SHALL be 0 in IDLE and DONE.
REQ-027 SHALL assert done for exactly the one cycle in DONE, then return to IDLE; done and cmd_ready are never high together.
REQ-028 SHALL, when abort is high on a RUN edge, skip the shift, keep the partial data and go to IDLE without asserting done; abort has priority over the final shift.
REQ-029 SHALL ignore abort in IDLE and DONE.
REQ-030 SHALL ignore cmd_valid whenever cmd_ready is low; no queuing.
REQ-031 SHALL hold parallel_out whenever no operation is performed.
REQ-032 SHALL keep the data unchanged during a RUN cycle only when abort is high.

Reset
REQ-033 SHALL, while rst_n is low, immediately force: state IDLE, register 0, remaining 0, parallel_out 0, ser_out 0, busy 0, done 0, cmd_ready 1.
REQ-034 SHALL discard an in-flight command on reset (including mid-RUN) with no done pulse; operation resumes at the first clock edge after rst_n is released.

Verification (N=8, CNT_W=4)
REQ-035 SHALL cover: rst_n low mid-RUN -> parallel_out 0x00, busy 0, done 0, cmd_ready 1 without waiting for a clock edge.
REQ-036 SHALL cover: LOAD 0xA5, then SHL C=3 with ser_in=1 -> values 0x4B, 0x97, 0x2F; ser_out 1, 0, 1; done one cycle after the 3rd shift.
REQ-037 SHALL cover: LOAD 0x90, then ASR C=2 -> 0xE4; ROR C=8 on 0x3C -> 0x3C after exactly 8 busy RUN cycles, ser_out 0,0,1,1,1,1,0,0.
REQ-038 SHALL cover: SHL C=0 and op 111 -> data unchanged, done high on the cycle after accept, cmd_ready high the cycle after that.
REQ-039 SHALL cover: LOAD 0xFF, then SHR C=5 with ser_in=0 and abort on the 3rd RUN cycle -> 0x3F held, no done, cmd_ready high on the next cycle.
REQ-040 SHALL cover: cmd_valid held high during RUN and DONE -> no second acceptance until IDLE; back-to-back commands accepted one cycle apart in IDLE.

Source files
------------

// File: rtl/multi_shift_register.sv
// Command-driven N-bit shift/rotate register with an IDLE/RUN/DONE sequencer.
// Shifts and rotates run one bit per cycle for cmd_count cycles; LOAD/CLEAR/NOP complete immediately.
module multi_shift_register #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [N-1:0]     parallel_in,
  input  logic             ser_in,
  input  logic             abort,
  output logic [N-1:0]     parallel_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ASR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  state_t           state, state_nxt;
  logic [N-1:0]     data, data_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [2:0]       op, op_nxt;

  function automatic logic [N-1:0] shift_one(input logic [2:0] f_op,
                                             input logic [N-1:0] d,
                                             input logic s);
    case (f_op)
      OP_SHL:  shift_one = {d[N-2:0], s};
      OP_SHR:  shift_one = {s, d[N-1:1]};
      OP_ASR:  shift_one = {d[N-1], d[N-1:1]};
      OP_ROL:  shift_one = {d[N-2:0], d[N-1]};
      OP_ROR:  shift_one = {d[0], d[N-1:1]};
      default: shift_one = d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      remaining <= '0;
      op        <= OP_NOP;
    end else begin
      state     <= state_nxt;
      data      <= data_nxt;
      remaining <= remaining_nxt;
      op        <= op_nxt;
    end
  end

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so anything presented in RUN/DONE is ignored, never queued.
  always_comb begin
    state_nxt     = state;
    data_nxt      = data;
    remaining_nxt = remaining;
    op_nxt        = op;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              data_nxt  = parallel_in;
              state_nxt = DONE;
            end
            OP_CLEAR: begin
              data_nxt  = '0;
              state_nxt = DONE;
            end
            OP_NOP: state_nxt = DONE;
            default: begin
              if (cmd_count == '0) begin
                state_nxt = DONE;
              end else begin
                op_nxt        = cmd_op;
                remaining_nxt = cmd_count;
                state_nxt     = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        // Abort wins even over the last shift: data is frozen and no done pulse follows.
        if (abort) begin
          remaining_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          data_nxt      = shift_one(op, data, ser_in);
          remaining_nxt = remaining - 1'b1;
          if (remaining == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ser_out = 1'b0;
    if (state == RUN) begin
      case (op)
        OP_SHL, OP_ROL:         ser_out = data[N-1];
        OP_SHR, OP_ASR, OP_ROR: ser_out = data[0];
        default:                ser_out = 1'b0;
      endcase
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign parallel_out = data;

endmodule
